// File: rtl/sprite_pkg.sv
// Shared constants, field codes, FSM states and descriptor layout for the sprite line engine.
package sprite_pkg;

  localparam int unsigned NUM_SPRITES = 8;
  localparam int unsigned LINE_WIDTH  = 320;
  localparam int unsigned XW          = 10;
  localparam int unsigned SPR_BITS    = 6;
  localparam int unsigned PIX_W       = 2;
  localparam int unsigned SPR_SIZE    = 16;

  localparam int unsigned SEL_W = $clog2(NUM_SPRITES);
  localparam int unsigned ROM_W = $clog2(SPR_SIZE / 2);
  localparam int unsigned AW    = $clog2(LINE_WIDTH);

  localparam logic [PIX_W-1:0] PIX_TRANSPARENT = '0;

  localparam logic [1:0] FLD_X   = 2'd0;
  localparam logic [1:0] FLD_Y   = 2'd1;
  localparam logic [1:0] FLD_IDX = 2'd2;
  localparam logic [1:0] FLD_EN  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SCAN,
    DRAW,
    DONE
  } state_e;

  typedef struct packed {
    logic                en;
    logic [SPR_BITS-1:0] idx;
    logic [XW-1:0]       y;
    logic [XW-1:0]       x;
  } sprite_desc_t;

endpackage

// File: rtl/sprite_line_engine_line_buffer_2bank.sv
// Ping-pong line RAM: one write port, one registered read port, bank chosen by address MSB.
module line_buffer_2bank
  import sprite_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW:0]      wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW:0]      rd_addr,
  output logic [PIX_W-1:0] rd_data
);

  logic [PIX_W-1:0] mem_q [2][LINE_WIDTH];
  logic [PIX_W-1:0] rdata_d;
  logic [PIX_W-1:0] rdata_q;

  // Pixel storage; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr[AW]][wr_addr[AW-1:0]] <= wr_data;
    end
  end

  // Disabled reads return transparent so the caller can gate range/validity.
  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      rdata_d = mem_q[rd_addr[AW]][rd_addr[AW-1:0]];
    end
  end

  // Registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rd_data = rdata_q;

endmodule

// File: rtl/sprite_line_engine.sv
// Scanline sprite renderer: renders the next line into one bank while the display reads the other.
module sprite_line_engine
  import sprite_pkg::*;
(
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  input  logic                i_Line_Start,
  input  logic [XW-1:0]       i_Next_Row,
  input  logic [XW-1:0]       i_Read_X,
  output logic [PIX_W-1:0]    o_Pixel,
  input  logic                i_Reg_Write,
  input  logic [SEL_W-1:0]    i_Reg_Sel,
  input  logic [1:0]          i_Reg_Field,
  input  logic [XW-1:0]       i_Reg_Data,
  output logic [SPR_BITS-1:0] o_Rom_Sprite,
  output logic [ROM_W-1:0]    o_Rom_Row,
  output logic [ROM_W-1:0]    o_Rom_Col,
  input  logic [PIX_W-1:0]    i_Rom_Pixel,
  output logic                o_Busy,
  output logic                o_Overrun
);

  sprite_desc_t        stg_q [NUM_SPRITES];
  sprite_desc_t        stg_d [NUM_SPRITES];
  sprite_desc_t        act_q [NUM_SPRITES];
  sprite_desc_t        act_d [NUM_SPRITES];
  state_e              state_q, state_d;
  logic                bank_q, bank_d;
  logic                valid_q, valid_d;
  logic                pend_q, pend_d;
  logic [XW-1:0]       row_q, row_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic [SEL_W-1:0]    spr_q, spr_d;
  logic                wr_pend_q, wr_pend_d;
  logic [XW:0]         wr_x_q, wr_x_d;
  logic [SPR_BITS-1:0] rom_spr_q, rom_spr_d;
  logic [ROM_W-1:0]    rom_row_q, rom_row_d;
  logic [ROM_W-1:0]    rom_col_q, rom_col_d;
  logic                busy_q, busy_d;
  logic                overrun_q, overrun_d;

  sprite_desc_t        cur_spr;
  logic [XW-1:0]       scan_dy;
  logic                scan_hit;
  logic                clr_we;
  logic                draw_we;
  logic                buf_we;
  logic [AW:0]         buf_waddr;
  logic [PIX_W-1:0]    buf_wdata;
  logic                buf_re;

  // Next-state: descriptor staging, line-start handover and the render sequencer.
  always_comb begin
    stg_d     = stg_q;
    act_d     = act_q;
    state_d   = state_q;
    bank_d    = bank_q;
    valid_d   = valid_q;
    pend_d    = pend_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    spr_d     = spr_q;
    wr_pend_d = 1'b0;
    wr_x_d    = wr_x_q;
    rom_spr_d = rom_spr_q;
    rom_row_d = rom_row_q;
    rom_col_d = rom_col_q;
    overrun_d = 1'b0;
    clr_we    = 1'b0;

    cur_spr  = act_q[spr_q];
    scan_dy  = row_q - cur_spr.y;
    scan_hit = cur_spr.en && (scan_dy < XW'(SPR_SIZE));

    if (i_Reg_Write) begin
      unique case (i_Reg_Field)
        FLD_X:   stg_d[i_Reg_Sel].x   = i_Reg_Data;
        FLD_Y:   stg_d[i_Reg_Sel].y   = i_Reg_Data;
        FLD_IDX: stg_d[i_Reg_Sel].idx = i_Reg_Data[SPR_BITS-1:0];
        FLD_EN:  stg_d[i_Reg_Sel].en  = i_Reg_Data[0];
        default: ;
      endcase
    end

    if (i_Line_Start) begin
      // An aborted render must never reach the display.
      overrun_d = (state_q != IDLE);
      valid_d   = (state_q == IDLE) ? pend_q : 1'b0;
      pend_d    = 1'b0;
      bank_d    = ~bank_q;
      row_d     = i_Next_Row;
      act_d     = stg_q;
      cnt_d     = '0;
      state_d   = CLEAR;
    end else begin
      unique case (state_q)
        CLEAR: begin
          clr_we = 1'b1;
          if (cnt_q == AW'(LINE_WIDTH - 1)) begin
            cnt_d   = '0;
            spr_d   = SEL_W'(NUM_SPRITES - 1);
            state_d = SCAN;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
        SCAN: begin
          if (scan_hit) begin
            cnt_d     = '0;
            rom_spr_d = cur_spr.idx;
            rom_row_d = scan_dy[ROM_W:1];
            rom_col_d = '0;
            state_d   = DRAW;
          end else if (spr_q == '0) begin
            state_d = DONE;
          end else begin
            spr_d = spr_q - SEL_W'(1);
          end
        end
        DRAW: begin
          // Address for column c is on the pins during cycle c; its data is written one cycle later.
          if (cnt_q < AW'(SPR_SIZE)) begin
            wr_pend_d = 1'b1;
            wr_x_d    = {1'b0, cur_spr.x} + (XW + 1)'(cnt_q);
            if (cnt_q < AW'(SPR_SIZE - 1)) begin
              rom_col_d = ROM_W'((cnt_q + AW'(1)) >> 1);
            end
            cnt_d = cnt_q + AW'(1);
          end else if (spr_q == '0) begin
            state_d = DONE;
          end else begin
            spr_d   = spr_q - SEL_W'(1);
            state_d = SCAN;
          end
        end
        DONE: begin
          pend_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // Line RAM port steering: clears and sprite writes never overlap.
  always_comb begin
    draw_we   = wr_pend_q && (i_Rom_Pixel != PIX_TRANSPARENT) && (wr_x_q < (XW + 1)'(LINE_WIDTH));
    buf_we    = clr_we || draw_we;
    buf_waddr = clr_we ? {bank_q, cnt_q} : {bank_q, wr_x_q[AW-1:0]};
    buf_wdata = clr_we ? PIX_TRANSPARENT : i_Rom_Pixel;
    buf_re    = valid_q && (i_Read_X < XW'(LINE_WIDTH));
  end

  // State and output registers.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      for (int i = 0; i < int'(NUM_SPRITES); i++) begin
        stg_q[i] <= '0;
        act_q[i] <= '0;
      end
      state_q   <= IDLE;
      bank_q    <= 1'b0;
      valid_q   <= 1'b0;
      pend_q    <= 1'b0;
      row_q     <= '0;
      cnt_q     <= '0;
      spr_q     <= '0;
      wr_pend_q <= 1'b0;
      wr_x_q    <= '0;
      rom_spr_q <= '0;
      rom_row_q <= '0;
      rom_col_q <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      stg_q     <= stg_d;
      act_q     <= act_d;
      state_q   <= state_d;
      bank_q    <= bank_d;
      valid_q   <= valid_d;
      pend_q    <= pend_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      spr_q     <= spr_d;
      wr_pend_q <= wr_pend_d;
      wr_x_q    <= wr_x_d;
      rom_spr_q <= rom_spr_d;
      rom_row_q <= rom_row_d;
      rom_col_q <= rom_col_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  line_buffer_2bank u_line_buffer (
    .clk     (i_Clk),
    .rst_n   (i_Rst_n),
    .wr_en   (buf_we),
    .wr_addr (buf_waddr),
    .wr_data (buf_wdata),
    .rd_en   (buf_re),
    .rd_addr ({~bank_q, i_Read_X[AW-1:0]}),
    .rd_data (o_Pixel)
  );

  assign o_Rom_Sprite = rom_spr_q;
  assign o_Rom_Row    = rom_row_q;
  assign o_Rom_Col    = rom_col_q;
  assign o_Busy       = busy_q;
  assign o_Overrun    = overrun_q;

endmodule

// File: tb/tb_sprite_line_engine.sv
// Directed bench for sprite_line_engine with a registered sprite ROM model.
module tb_sprite_line_engine;
  import sprite_pkg::*;

  logic                i_Clk = 1'b0;
  logic                i_Rst_n;
  logic                i_Line_Start;
  logic [XW-1:0]       i_Next_Row;
  logic [XW-1:0]       i_Read_X;
  logic [PIX_W-1:0]    o_Pixel;
  logic                i_Reg_Write;
  logic [SEL_W-1:0]    i_Reg_Sel;
  logic [1:0]          i_Reg_Field;
  logic [XW-1:0]       i_Reg_Data;
  logic [SPR_BITS-1:0] o_Rom_Sprite;
  logic [ROM_W-1:0]    o_Rom_Row;
  logic [ROM_W-1:0]    o_Rom_Col;
  logic [PIX_W-1:0]    i_Rom_Pixel;
  logic                o_Busy;
  logic                o_Overrun;

  logic [PIX_W-1:0] rom [64][8][8];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc;

  sprite_line_engine dut (
    .i_Clk        (i_Clk),
    .i_Rst_n      (i_Rst_n),
    .i_Line_Start (i_Line_Start),
    .i_Next_Row   (i_Next_Row),
    .i_Read_X     (i_Read_X),
    .o_Pixel      (o_Pixel),
    .i_Reg_Write  (i_Reg_Write),
    .i_Reg_Sel    (i_Reg_Sel),
    .i_Reg_Field  (i_Reg_Field),
    .i_Reg_Data   (i_Reg_Data),
    .o_Rom_Sprite (o_Rom_Sprite),
    .o_Rom_Row    (o_Rom_Row),
    .o_Rom_Col    (o_Rom_Col),
    .i_Rom_Pixel  (i_Rom_Pixel),
    .o_Busy       (o_Busy),
    .o_Overrun    (o_Overrun)
  );

  always #5 i_Clk = ~i_Clk;

  // Synchronous ROM: data one cycle after the address.
  always @(posedge i_Clk) i_Rom_Pixel <= rom[o_Rom_Sprite][o_Rom_Row][o_Rom_Col];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic reg_wr(input int sel, input logic [1:0] fld, input int data);
    @(negedge i_Clk);
    i_Reg_Write = 1'b1;
    i_Reg_Sel   = SEL_W'(sel);
    i_Reg_Field = fld;
    i_Reg_Data  = XW'(data);
    @(negedge i_Clk);
    i_Reg_Write = 1'b0;
  endtask

  task automatic set_sprite(input int sel, input int x, input int y, input int idx, input int en);
    reg_wr(sel, FLD_X, x);
    reg_wr(sel, FLD_Y, y);
    reg_wr(sel, FLD_IDX, idx);
    reg_wr(sel, FLD_EN, en);
  endtask

  task automatic line_start(input int row);
    @(negedge i_Clk);
    i_Line_Start = 1'b1;
    i_Next_Row   = XW'(row);
    @(negedge i_Clk);
    i_Line_Start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, output int n);
    n = 0;
    while (o_Busy === 1'b1 && n < 800) begin
      @(negedge i_Clk);
      n++;
    end
    chk(tag, 32'(o_Busy), 32'd0);
  endtask

  task automatic rd(input string tag, input int x, input int exp);
    @(negedge i_Clk);
    i_Read_X = XW'(x);
    @(posedge i_Clk);
    #1;
    chk(tag, 32'(o_Pixel), 32'(exp));
  endtask

  initial begin
    for (int s = 0; s < 64; s++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          rom[s][r][c] = '0;
    i_Rst_n = 1'b0; i_Line_Start = 1'b0; i_Next_Row = '0; i_Read_X = '0;
    i_Reg_Write = 1'b0; i_Reg_Sel = '0; i_Reg_Field = '0; i_Reg_Data = '0;
    repeat (3) @(negedge i_Clk);
    i_Rst_n = 1'b1;
    @(negedge i_Clk);

    // Reset state
    chk("rst_pixel", 32'(o_Pixel), 0);
    chk("rst_busy", 32'(o_Busy), 0);
    chk("rst_overrun", 32'(o_Overrun), 0);
    chk("rst_rom_spr", 32'(o_Rom_Sprite), 0);
    chk("rst_rom_row", 32'(o_Rom_Row), 0);
    chk("rst_rom_col", 32'(o_Rom_Col), 0);

    // Single sprite, first texel only
    rom[1][0][0] = 2'd2;
    set_sprite(0, 10, 5, 1, 1);
    line_start(5);
    chk("t1_busy", 32'(o_Busy), 1);
    rd("t1_not_valid", 10, 0);
    wait_idle("t1_idle", cyc);
    line_start(5);
    rd("t1_x9", 9, 0);
    rd("t1_x10", 10, 2);
    rd("t1_x11", 11, 2);
    rd("t1_x12", 12, 0);

    // Priority: sprite 0 over sprite 3, transparent texel shows sprite 3
    wait_idle("t2_pre_idle", cyc);
    for (int c = 0; c < 8; c++) begin
      rom[3][0][c] = 2'd1;
      rom[2][0][c] = 2'd3;
    end
    rom[2][0][1] = 2'd0;
    set_sprite(0, 20, 0, 2, 1);
    set_sprite(3, 20, 0, 3, 1);
    line_start(0);
    chk("t2_no_overrun", 32'(o_Overrun), 0);
    wait_idle("t2_idle", cyc);
    line_start(0);
    rd("t2_x10", 10, 0);
    rd("t2_x19", 19, 0);
    rd("t2_x20", 20, 3);
    rd("t2_x22", 22, 1);
    rd("t2_x23", 23, 1);
    rd("t2_x24", 24, 3);
    rd("t2_x35", 35, 3);
    rd("t2_x36", 36, 0);

    // Right-edge clipping and render time
    wait_idle("t3_pre_idle", cyc);
    for (int c = 0; c < 8; c++) rom[4][0][c] = 2'd2;
    reg_wr(3, FLD_EN, 0);
    set_sprite(0, 312, 0, 4, 1);
    line_start(0);
    wait_idle("t3_idle", cyc);
    chk("t3_busy_budget", 32'(cyc <= 464), 1);
    line_start(0);
    rd("t3_x311", 311, 0);
    rd("t3_x312", 312, 2);
    rd("t3_x319", 319, 2);
    rd("t3_x320", 320, 0);
    rd("t3_x0", 0, 0);
    rd("t3_x7", 7, 0);

    // Vertical wrap: y=1020, row 2 -> dy 6 -> ROM row 3
    wait_idle("t4_pre_idle", cyc);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        rom[5][r][c] = (r == 3) ? 2'd3 : 2'd1;
    set_sprite(0, 100, 1020, 5, 1);
    line_start(2);
    wait_idle("t4_idle", cyc);
    chk("t4_rom_spr", 32'(o_Rom_Sprite), 5);
    chk("t4_rom_row", 32'(o_Rom_Row), 3);
    chk("t4_rom_col", 32'(o_Rom_Col), 7);
    line_start(2);
    rd("t4_x99", 99, 0);
    rd("t4_x100", 100, 3);
    rd("t4_x115", 115, 3);
    rd("t4_x116", 116, 0);

    // Overrun: second line start 100 cycles after the first
    wait_idle("t5_pre_idle", cyc);
    line_start(2);
    chk("t5_first_no_overrun", 32'(o_Overrun), 0);
    repeat (98) @(negedge i_Clk);
    line_start(2);
    chk("t5_overrun_pulse", 32'(o_Overrun), 1);
    @(negedge i_Clk);
    chk("t5_overrun_single", 32'(o_Overrun), 0);
    rd("t5_aborted_x100", 100, 0);
    rd("t5_aborted_x0", 0, 0);
    wait_idle("t5_idle", cyc);
    line_start(2);
    rd("t5_recovered_x100", 100, 3);

    // Descriptor write coinciding with line start takes effect one line later
    wait_idle("t6_pre_idle", cyc);
    set_sprite(0, 40, 0, 4, 1);
    line_start(0);
    wait_idle("t6_idle_a", cyc);
    @(negedge i_Clk);
    i_Line_Start = 1'b1;
    i_Next_Row   = '0;
    i_Reg_Write  = 1'b1;
    i_Reg_Sel    = '0;
    i_Reg_Field  = FLD_X;
    i_Reg_Data   = XW'(50);
    @(negedge i_Clk);
    i_Line_Start = 1'b0;
    i_Reg_Write  = 1'b0;
    wait_idle("t6_idle_b", cyc);
    line_start(0);
    rd("t6_old_x39", 39, 0);
    rd("t6_old_x40", 40, 2);
    rd("t6_old_x55", 55, 2);
    rd("t6_old_x56", 56, 0);
    wait_idle("t6_idle_c", cyc);
    line_start(0);
    rd("t6_new_x40", 40, 0);
    rd("t6_new_x49", 49, 0);
    rd("t6_new_x50", 50, 2);
    rd("t6_new_x65", 65, 2);
    rd("t6_new_x66", 66, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sprite_line_engine.md
Name: sprite_line_engine

Overview:
Multi-sprite scanline renderer for the VGA sprite path. It holds NUM_SPRITES independent sprite descriptors: x, y, ROM index and enable. While line N is on screen, it renders line N+1 into a ping-pong line buffer with transparency and fixed priority. The display side reads the other bank with 1-cycle latency. The sprite ROM sits outside the block; the playfield merge downstream is unchanged.

Parameters:
NUM_SPRITES, 8, number of sprite descriptors (power of 2, ≥2)
LINE_WIDTH, 320, buffer pixels per line (half-res; the display feeds column>>1)
XW, 10, width of x, y and row coordinates
SPR_BITS, 6, sprite ROM index width
PIX_W, 2, pixel/colour-code width; code 0 is transparent
SPR_SIZE, 16, on-screen sprite edge in buffer rows/pixels; ROM is SPR_SIZE/2 square, each texel doubled

Ports:
i_Clk  in  1  system clock
i_Rst_n  in  1  reset, asynchronous assert, active-low
i_Line_Start  in  1  one-cycle pulse at column 0 of each scanline
i_Next_Row  in  XW  row to render, valid with i_Line_Start
i_Read_X  in  XW  display read address in buffer pixels
o_Pixel  out  PIX_W  display-bank pixel at i_Read_X, registered
i_Reg_Write  in  1  descriptor write strobe
i_Reg_Sel  in  clog2(NUM_SPRITES)  descriptor select
i_Reg_Field  in  2  0=x, 1=y, 2=index, 3=enable(bit0)
i_Reg_Data  in  XW  write data, low bits used for index/enable
o_Rom_Sprite  out  SPR_BITS  ROM sprite index
o_Rom_Row  out  3  ROM texel row
o_Rom_Col  out  3  ROM texel column
i_Rom_Pixel  in  PIX_W  ROM data, 1 cycle after the address
o_Busy  out  1  render in progress
o_Overrun  out  1  one-cycle pulse: render aborted by a new i_Line_Start

Behaviour:
- Reset:
  - all descriptors and their shadows = 0, enables = 0
  - state IDLE, write bank = 0, valid flag = 0
  - o_Pixel = 0, o_Busy = 0, o_Overrun = 0, ROM address outputs = 0
  - line RAM is not reset.
- Descriptor writes land in a staging copy on any cycle. The staging copy is copied into the active copy only on i_Line_Start, so a line never renders from a half-updated descriptor set.
- On i_Line_Start:
  - toggle the bank; the display now reads what was just rendered
  - valid <= valid_pending
  - latch i_Next_Row; copy staging to active; enter CLEAR.
- While valid = 0, o_Pixel = 0.
- States:
  - IDLE
  - CLEAR: write 0 to write-bank addresses 0..LINE_WIDTH-1, one per cycle.
  - SCAN: test one sprite per cycle, from index NUM_SPRITES-1 down to 0. Hit iff the sprite is enabled and dy = (row - y) mod 2^XW < SPR_SIZE; on a hit, go to DRAW. After index 0, go to DONE.
  - DRAW: SPR_SIZE cycles, c = 0..SPR_SIZE-1.
    - ROM address: sprite=index, row=dy>>1, col=c>>1.
    - One cycle later, write i_Rom_Pixel at address x+c, only if the pixel ≠ 0 and x+c < LINE_WIDTH (no horizontal wrap, clipping only).
    - One drain cycle, then return to SCAN at the next index.
  - DONE: set valid_pending = 1, go to IDLE.
- Priority: lower index is drawn last, so it wins on overlap. Transparent pixels never overwrite.
- Vertical wrap is intentional: y near 2^XW-1 appears at the top rows.
- Worst case is LINE_WIDTH + NUM_SPRITES + NUM_SPRITES*(SPR_SIZE+1) = 464 cycles with defaults, under 800.
- o_Busy = 1 in CLEAR, SCAN, DRAW and DONE.
- i_Line_Start while not IDLE:
  - abort; pulse o_Overrun; clear valid_pending (the aborted buffer must never be shown)
  - then perform the normal line-start actions.
- Display read: o_Pixel <= (i_Read_X < LINE_WIDTH) ? bank[read][i_Read_X] : 0, 1-cycle latency. Simultaneous render writes go only to the other bank, so there is no read/write collision.
- A descriptor write in the same cycle as i_Line_Start reaches staging but not active; it takes effect on the following line.

Decomposition:
- Package sprite_pkg:
  - field codes FLD_X/FLD_Y/FLD_IDX/FLD_EN
  - state enum IDLE/CLEAR/SCAN/DRAW/DONE
  - PIX_W and transparent code 0
- Sub-module line_buffer_2bank: 2×LINE_WIDTH×PIX_W RAM, one write port and one registered read port; bank select is an address MSB.

Test Plan:
- Reset, then sprite 0 at x=10, y=5, index 1, enabled, ROM texel(0,0)=2; Line_Start with row=5, then Line_Start again -> o_Pixel at Read_X 10 and 11 = 2, at 9 = 0.
- Sprites 3 and 0 both at x=20, y=0, all texels non-zero -> at overlap pixels o_Pixel equals sprite 0's ROM data; texel=0 in sprite 0 shows sprite 3.
- x=312, y=0 -> pixels 312..319 drawn, no write at 0..7, o_Busy drops within 464 cycles.
- y=1020 (mod 1024), row=2 -> hit with dy=6, so ROM row 3 is used.
- Second Line_Start 100 cycles after the first -> o_Overrun pulses once; the next displayed line reads 0 everywhere.
- Write x=50 in the same cycle as Line_Start while the old x=40 is active -> that line renders at 40; the next line renders at 50.
